data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Data-memory responder on the far end of the MEM-stage load/store interface.
//   Accepts one MEMRead/MEMWrite request at a time and models a multi-cycle RAM.
//   Holds the pipeline with mem_stall until the access completes, then returns
//   RD with a one-cycle mem_ready pulse.
//   Replaces the zero-wait data memory so MEM_STAGE can run against realistic latency.
// PARAMETERS
//   ADDR_W    10   word-address bits; depth = 2**ADDR_W 32-bit words
//   WAIT_CYC  2    wait states before commit, 0..15 (4-bit counter)
// PORTS
//   clk_50    in   1   system clock, rising edge
//   rst       in   1   asynchronous, active-low reset
//   MEMRead   in   1   load request from MEM stage
//   MEMWrite  in   1   store request from MEM stage
//   ADDR      in   32  byte address; word index = ADDR[ADDR_W+1:2]
//   WD        in   32  store data
//   RD        out  32  load data, registered, held until the next completed load
//   mem_stall out  1   pipeline hold; high while a request is in service
//   mem_ready out  1   one-cycle pulse in the completion cycle
//   misalign  out  1   one-cycle pulse with mem_ready when ADDR[1:0] != 0
// BEHAVIOUR
//   - Reset (rst=0, async): FSM=IDLE, counter=0, RD=0, mem_ready=0, misalign=0.
//     mem_stall is forced to 0 while rst=0. A pending store is discarded.
//     The RAM array is never reset.
//   - FSM states IDLE, WAIT, DONE:
//     IDLE: request = MEMRead|MEMWrite. mem_stall = request (combinational).
//       On request, latch the op, word index and WD.
//       If ADDR[1:0] != 0, go to DONE and flag misaligned.
//       Else if WAIT_CYC = 0, go to DONE. Else go to WAIT with counter = 1.
//     WAIT: mem_stall = 1. While counter < WAIT_CYC, increment the counter.
//       At counter = WAIT_CYC, go to DONE.
//     DONE: mem_stall = 0, mem_ready = 1, misalign = latched flag.
//       Always return to IDLE; no request is accepted in DONE.
//   - RAM commit happens on the clock edge that enters DONE, and only when aligned:
//     store: mem[idx] <= latched WD; load: RD <= mem[idx].
//     RD is valid throughout DONE and held afterwards.
//   - Latency: mem_stall is high for WAIT_CYC+1 cycles (request cycle + waits).
//     mem_ready is asserted in cycle WAIT_CYC+1 after the request cycle.
//     A misaligned request stalls 1 cycle regardless of WAIT_CYC.
//   - Requests presented outside IDLE are ignored. The MEM stage must hold its
//     inputs stable while mem_stall = 1.
//   - MEMRead and MEMWrite both high: treated as a store; RD unchanged.
//   - ADDR bits above ADDR_W+1 are ignored, so addresses alias modulo 4*2**ADDR_W.
//   - Misaligned requests perform no write and leave RD unchanged.
// TESTING
//   1 WAIT_CYC=2; write ADDR=0x10 WD=0xDEADBEEF -> mem_stall=1 for cycles 0..2;
//     cycle 3: mem_ready=1, mem_stall=0; mem[4]=0xDEADBEEF.
//   2 Then read ADDR=0x10 -> stall for 3 cycles; RD=0xDEADBEEF in the mem_ready cycle
//     and held afterwards.
//   3 Read ADDR=0x13 -> stall 1 cycle; next cycle mem_ready=1, misalign=1;
//     RD unchanged, no RAM write.
//   4 MEMRead=MEMWrite=1, ADDR=0x20, WD=0x1234 -> mem[8]=0x1234, RD unchanged,
//     same timing as test 1.
//   5 Write ADDR=0x8 WD=0xAAAA with mem[2]=0x5555; drive rst=0 during WAIT ->
//     outputs go to 0 immediately, FSM returns to IDLE;
//     after release, read 0x8 returns 0x5555.
//   6 WAIT_CYC=0, ADDR_W=10: write ADDR=0x1010 WD=0x77, then read ADDR=0x10 ->
//     each access stalls 1 cycle; read returns 0x77 (aliasing).

Source files
------------

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Data-memory responder that sits at the far end of the MEM-stage load/store
//   interface. It serves one load or store at a time against a multi-cycle RAM
//   model. While an access is in flight it holds the pipeline with mem_stall.
//   When the access completes it returns the load data on RD and raises
//   mem_ready for one cycle.
//
// Parameters
//   ADDR_W    word-address bits; the RAM holds 2**ADDR_W 32-bit words
//   WAIT_CYC  wait states inserted before commit, 0..15
//
// Ports
//   clk_50    in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   MEMRead   in   load request
//   MEMWrite  in   store request (has priority when both are high)
//   ADDR      in   byte address; word index = ADDR[ADDR_W+1:2]
//   WD        in   store data
//   RD        out  registered load data, held until the next completed load
//   mem_stall out  pipeline hold while a request is in service
//   mem_ready out  one-cycle completion pulse
//   misalign  out  one-cycle pulse alongside mem_ready for a misaligned access
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        MEMRead,
  input  logic        MEMWrite,
  input  logic [31:0] ADDR,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        mem_stall,
  output logic        mem_ready,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYC);

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                stall_raw;

  // Request captured at acceptance, used while the access is in service.
  logic                lat_write;
  logic                lat_misal;
  logic [ADDR_W-1:0]   lat_idx;
  logic [31:0]         lat_wd;

  logic [31:0]         mem [2**ADDR_W];

  logic                request;
  logic                addr_misal;
  logic [ADDR_W-1:0]   req_idx;
  logic                accept;

  // Operation that commits on the edge entering DONE. With zero wait states
  // that edge is the acceptance edge itself, so the live inputs are used
  // instead of the not-yet-latched copies.
  logic                commit_write;
  logic                commit_misal;
  logic [ADDR_W-1:0]   commit_idx;
  logic [31:0]         commit_wd;
  logic                enter_done;
  logic                do_store;
  logic                do_load;

  // Address bits above the word index alias and are intentionally ignored.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^ADDR[31:ADDR_W+2];

  assign request    = MEMRead | MEMWrite;
  assign addr_misal = |ADDR[1:0];
  assign req_idx    = ADDR[ADDR_W+1:2];
  assign accept     = (state == S_IDLE) && request;

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_raw = 1'b0;
    mem_ready = 1'b0;
    misalign  = 1'b0;
    unique case (state)
      S_IDLE: begin
        stall_raw = request;
        if (request) begin
          if (addr_misal || (WAIT_CNT == 4'd0)) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        stall_raw = 1'b1;
        if (cnt < WAIT_CNT) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        mem_ready = 1'b1;
        misalign  = lat_misal;
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The pipeline must never be held while the responder is in reset.
  assign mem_stall = stall_raw & rst;

  always_comb begin
    if (state == S_IDLE) begin
      commit_write = MEMWrite;
      commit_misal = addr_misal;
      commit_idx   = req_idx;
      commit_wd    = WD;
    end else begin
      commit_write = lat_write;
      commit_misal = lat_misal;
      commit_idx   = lat_idx;
      commit_wd    = lat_wd;
    end
  end

  assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);
  assign do_store   = enter_done && !commit_misal && commit_write;
  assign do_load    = enter_done && !commit_misal && !commit_write;

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, regardless of statement order.
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_misal <= 1'b0;
      lat_idx   <= '0;
      lat_wd    <= '0;
      RD        <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_write <= MEMWrite;
        lat_misal <= addr_misal;
        lat_idx   <= req_idx;
        lat_wd    <= WD;
      end
      if (do_load) begin
        RD <= mem[commit_idx];
      end
    end
  end

  // NOTE: the RAM array has no reset; clearing it would prevent inference of
  // a block RAM. An access cut short by reset never reaches this write.
  always_ff @(posedge clk_50) begin
    if (do_store) begin
      mem[commit_idx] <= commit_wd;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Two instances share the clock and reset. Index 0 has WAIT_CYC=0 and index 1
//   has WAIT_CYC=2. A reference model (word array + expected RD per instance)
//   predicts the completion timing, the misalign flag and the load data for
//   the directed and the randomized accesses.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] addr      [2];
  logic [31:0] wd        [2];
  logic [31:0] rd        [2];
  logic        stall     [2];
  logic        ready     [2];
  logic        misal     [2];

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference model
  logic [31:0] model_mem   [2][1024];
  bit          model_valid [2][1024];
  logic [31:0] exp_rd      [2];
  bit          rd_known    [2];

  always #10 clk_50 = ~clk_50;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYC(0)) u_dut_w0 (
    .clk_50   (clk_50),
    .rst      (rst),
    .MEMRead  (mem_read[0]),
    .MEMWrite (mem_write[0]),
    .ADDR     (addr[0]),
    .WD       (wd[0]),
    .RD       (rd[0]),
    .mem_stall(stall[0]),
    .mem_ready(ready[0]),
    .misalign (misal[0])
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYC(2)) u_dut_w2 (
    .clk_50   (clk_50),
    .rst      (rst),
    .MEMRead  (mem_read[1]),
    .MEMWrite (mem_write[1]),
    .ADDR     (addr[1]),
    .WD       (wd[1]),
    .RD       (rd[1]),
    .mem_stall(stall[1]),
    .mem_ready(ready[1]),
    .misalign (misal[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Apply the architectural effect of one completed access to the model.
  task automatic model_access(input int d, input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] wdat);
    int idx;
    idx = int'(a[11:2]);
    if (a[1:0] != 2'b00) return;
    if (w) begin
      model_mem[d][idx]   = wdat;
      model_valid[d][idx] = 1'b1;
    end else if (r) begin
      if (model_valid[d][idx]) begin
        exp_rd[d]   = model_mem[d][idx];
        rd_known[d] = 1'b1;
      end else begin
        rd_known[d] = 1'b0;
      end
    end
  endtask

  task automatic drop_inputs(input int d);
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    addr[d]      = '0;
    wd[d]        = '0;
  endtask

  // One complete request: present it, hold it through the stall, check the
  // completion cycle and the idle cycle that follows.
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wdat, input string tag);
    bit mis;
    int lat;
    mis = (a[1:0] != 2'b00);
    lat = mis ? 1 : wait_of(d) + 1;
    @(negedge clk_50);
    mem_read[d]  = r;
    mem_write[d] = w;
    addr[d]      = a;
    wd[d]        = wdat;
    #1;
    check({tag, ".stall_req"}, 32'(stall[d]), 32'd1);
    check({tag, ".ready_req"}, 32'(ready[d]), 32'd0);
    model_access(d, r, w, a, wdat);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk_50);
      if (c < lat) begin
        check({tag, ".stall_wait"}, 32'(stall[d]), 32'd1);
        check({tag, ".ready_wait"}, 32'(ready[d]), 32'd0);
      end else begin
        check({tag, ".stall_done"}, 32'(stall[d]), 32'd0);
        check({tag, ".ready_done"}, 32'(ready[d]), 32'd1);
        check({tag, ".misalign"},   32'(misal[d]), 32'(mis));
        if (rd_known[d]) check({tag, ".rd_done"}, rd[d], exp_rd[d]);
      end
    end
    drop_inputs(d);
    @(negedge clk_50);
    check({tag, ".ready_after"}, 32'(ready[d]), 32'd0);
    check({tag, ".stall_after"}, 32'(stall[d]), 32'd0);
    check({tag, ".misal_after"}, 32'(misal[d]), 32'd0);
    if (rd_known[d]) check({tag, ".rd_held"}, rd[d], exp_rd[d]);
  endtask

  initial begin
    logic [9:0]  pool [2][8];
    logic [31:0] a;
    int          k;
    int          d;

    for (int i = 0; i < 2; i++) begin
      drop_inputs(i);
      exp_rd[i]   = '0;
      rd_known[i] = 1'b1;
      for (int j = 0; j < 1024; j++) model_valid[i][j] = 1'b0;
    end

    // Reset state, with a request already presented: stall must stay low.
    rst = 1'b0;
    mem_read[1] = 1'b1;
    addr[1]     = 32'h10;
    #25;
    check("rst.stall", 32'(stall[1]), 32'd0);
    check("rst.ready", 32'(ready[1]), 32'd0);
    check("rst.misal", 32'(misal[1]), 32'd0);
    check("rst.rd",    rd[1],         32'd0);
    check("rst.rd_w0", rd[0],         32'd0);
    drop_inputs(1);
    @(negedge clk_50);
    rst = 1'b1;

    // Store then load with two wait states.
    access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "t1_store");
    access(1, 1'b1, 1'b0, 32'h10, 32'h0,        "t2_load");
    // Misaligned load and store: one-cycle stall, no RAM or RD effect.
    access(1, 1'b1, 1'b0, 32'h13, 32'h0,        "t3_misal_load");
    access(1, 1'b0, 1'b1, 32'h11, 32'h0BAD0BAD, "t3_misal_store");
    access(1, 1'b1, 1'b0, 32'h10, 32'h0,        "t3_reload");
    // Both strobes high behaves as a store.
    access(1, 1'b1, 1'b1, 32'h20, 32'h1234,     "t4_both");
    access(1, 1'b1, 1'b0, 32'h20, 32'h0,        "t4_reload");

    // Reset in the middle of a store wait: the store is discarded.
    access(1, 1'b0, 1'b1, 32'h8, 32'h5555,      "t5_prime");
    @(negedge clk_50);
    mem_write[1] = 1'b1;
    addr[1]      = 32'h8;
    wd[1]        = 32'hAAAA;
    @(negedge clk_50);
    check("t5.stall_wait", 32'(stall[1]), 32'd1);
    rst = 1'b0;
    #1;
    check("t5.stall_rst", 32'(stall[1]), 32'd0);
    check("t5.ready_rst", 32'(ready[1]), 32'd0);
    check("t5.misal_rst", 32'(misal[1]), 32'd0);
    check("t5.rd_rst",    rd[1],         32'd0);
    for (int i = 0; i < 2; i++) begin
      exp_rd[i]   = '0;
      rd_known[i] = 1'b1;
    end
    drop_inputs(1);
    @(negedge clk_50);
    rst = 1'b1;
    access(1, 1'b1, 1'b0, 32'h8, 32'h0,         "t5_reload");

    // Zero wait states and address aliasing.
    access(0, 1'b0, 1'b1, 32'h1010, 32'h77,     "t6_store");
    access(0, 1'b1, 1'b0, 32'h10,   32'h0,      "t6_load");
    access(0, 1'b1, 1'b0, 32'h2,    32'h0,      "t6_misal");

    // Randomized accesses over a small pool of word indices per instance.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 8; j++) pool[i][j] = 10'($urandom_range(0, 1023));
    for (int n = 0; n < 60; n++) begin
      d = n % 2;
      k = $urandom_range(0, 3);
      a = $urandom;
      a[11:2] = pool[d][$urandom_range(0, 7)];
      a[1:0]  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      access(d, (k != 1), (k == 1 || k == 2), a, $urandom, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
